acc_core_mc: RTL and testbench
==============================

Name: acc_core_mc

Overview:
Multi-channel successor to acc_core. It keeps NUM_CH independent accumulators, selected per sample by ch_i, in either running-sum or running-max mode. Each accepted sample is echoed with its updated value. When run_i falls, the block drains every channel's final result in channel order. It sits between the input sample stream and the result collector.

Parameters:
IN_DATA_WIDTH, 8, width of unsigned input sample
DWIDTH, IN_DATA_WIDTH*4, accumulator/result width; must be > IN_DATA_WIDTH
NUM_CH, 4, number of channels; must be >= 2
CH_WIDTH, $clog2(NUM_CH), channel index width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
run_i  in  1  session enable; rising edge starts a session, falling edge starts drain
mode_i  in  1  0 = sum, 1 = max; sampled only on session start
valid_i  in  1  sample strobe
ch_i  in  CH_WIDTH  target channel of sample
number_i  in  IN_DATA_WIDTH  sample, unsigned, zero-extended to DWIDTH
valid_o  out  1  output beat valid
ch_o  out  CH_WIDTH  channel of beat
result_o  out  DWIDTH  accumulator value of channel ch_o
final_o  out  1  beat is a drain (final) result
last_o  out  1  beat is the final drain beat (ch_o = NUM_CH-1)
ovf_o  out  1  sticky overflow flag of channel ch_o
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE; all accumulators and overflow flags 0; all outputs 0. Reset mid-session or mid-drain aborts with no further beats.
- Clock and reset: one clock; reset is asynchronous and active-low.
- States: IDLE, RUN, DRAIN. All outputs are registered.
- IDLE: if run_i=1, clear all accumulators and overflow flags, latch mode_i, and go to RUN. A valid_i in this same cycle is accepted against the cleared value, so the first sample can coincide with run_i rising.
- RUN: a sample is accepted only if valid_i=1 and run_i=1.
  - Accepted sample: acc[ch_i] <= op(acc[ch_i], number_i).
  - Next edge: valid_o=1, ch_o=ch_i, result_o=new value, final_o=0. Echo latency is 1 cycle.
  - run_i=0 goes to DRAIN. valid_i in that cycle is ignored.
- DRAIN: index k = 0..NUM_CH-1, one per cycle. Each cycle produces valid_o=1, ch_o=k, result_o=acc[k], ovf_o=ovf[k], final_o=1, last_o=(k=NUM_CH-1), then IDLE.
  - First drain beat appears 2 edges after the edge on which run_i was sampled low.
  - The echo of the last RUN sample never collides with a drain beat.
  - run_i and valid_i are ignored during DRAIN. run_i=1 on return to IDLE starts a new session the following cycle.
- Accumulators hold their values in IDLE until the next session start.
- Arithmetic:
  - sum: acc + zero-extended number, computed in DWIDTH+1 bits; a carry-out sets ovf[ch], sticky until session start.
  - max: acc = max(acc, number); never overflows.
- Outputs not listed for a cycle: valid_o=0, final_o=0, last_o=0. Other outputs hold their values.

Optional Feature:
ACC_SAT_EN
- Defined: on sum overflow, the accumulator clamps to all-ones and stays there on further adds; ovf is set.
- Undefined: the accumulator wraps modulo 2^DWIDTH; ovf is still set.
- Max mode is unaffected either way.

Decomposition:
- Package acc_pkg: state encoding (IDLE/RUN/DRAIN), mode constants (ACC_MODE_SUM=0, ACC_MODE_MAX=1).
- Sub-module acc_alu: combinational op with inputs acc, number, mode; outputs next value and ovf. Saturation lives inside it under ACC_SAT_EN.
- Channel storage is a register array in the top level.

Test Plan:
- run_i=1, mode=sum, with run_i rising together with valid_i: ch0 gets 1, gap, then ch0 gets 3 -> echo beats ch0=1, then ch0=4. run_i low -> drain beats ch0=4, ch1=0, ch2=0, ch3=0, last_o only on ch3.
- Interleaved sum: ch1 5, ch2 7, ch1 10, ch3 255 on consecutive cycles -> drain ch0=0, ch1=15, ch2=7, ch3=255, all final_o=1.
- Max mode: ch2 gets 9, 3, 200, 17 -> echoes 9, 9, 200, 200; drain ch2=200.
- Overflow, with DWIDTH=32 reduced to DWIDTH=9 instance: ch0 gets 255, 255, 255 -> sum 765 exceeds 511.
  - Without ACC_SAT_EN: drain ch0=253 with ovf_o=1.
  - With ACC_SAT_EN: drain ch0=511 with ovf_o=1.
- reset_n pulsed low during DRAIN after ch1 beat -> no further beats; busy_o=0, all outputs 0. A new session starts with accumulators at 0.
- Session back-to-back: run_i reasserted during DRAIN -> ignored until IDLE, then new session starts with ch values cleared. valid_i during DRAIN has no effect on any channel.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared encodings for the multi-channel accumulator (acc_core_mc and acc_alu).
package acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } acc_state_t;

    localparam logic ACC_MODE_SUM = 1'b0;
    localparam logic ACC_MODE_MAX = 1'b1;

endpackage

// File: rtl/acc_alu.sv
// Combinational accumulate step: running sum with carry-out, or running max.
// ACC_SAT_EN: a sum carry clamps the result to all-ones instead of wrapping.
module acc_alu
    import acc_pkg::*;
#(
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH        = IN_DATA_WIDTH * 4
) (
    input  logic [DWIDTH-1:0]        acc,
    input  logic [IN_DATA_WIDTH-1:0] number,
    input  logic                     mode,
    output logic [DWIDTH-1:0]        nxt,
    output logic                     ovf
);

    logic [DWIDTH-1:0] num_ext;
    logic [DWIDTH:0]   sum_w;

    assign num_ext = DWIDTH'(number);
    assign sum_w   = {1'b0, acc} + {1'b0, num_ext};

    always_comb begin
        nxt = acc;
        ovf = 1'b0;
        if (mode == ACC_MODE_MAX) begin
            nxt = (num_ext > acc) ? num_ext : acc;
        end else begin
            ovf = sum_w[DWIDTH];
`ifdef ACC_SAT_EN
            nxt = sum_w[DWIDTH] ? '1 : sum_w[DWIDTH-1:0];
`else
            nxt = sum_w[DWIDTH-1:0];
`endif
        end
    end

endmodule

// File: rtl/acc_core_mc.sv
// Multi-channel accumulator: per-channel sum/max, per-sample echo, ordered drain on run_i fall.
// ACC_SAT_EN (applied inside acc_alu) selects saturating instead of wrapping sums.
//
// state    | meaning
// ST_IDLE  | waiting for run_i; accumulators hold the previous session's values
// ST_RUN   | accepting samples and echoing each updated channel value
// ST_DRAIN | one gap cycle, then one final beat per channel in index order
module acc_core_mc
    import acc_pkg::*;
#(
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH        = IN_DATA_WIDTH * 4,
    parameter int NUM_CH        = 4,
    parameter int CH_WIDTH      = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     run_i,
    input  logic                     mode_i,
    input  logic                     valid_i,
    input  logic [CH_WIDTH-1:0]      ch_i,
    input  logic [IN_DATA_WIDTH-1:0] number_i,
    output logic                     valid_o,
    output logic [CH_WIDTH-1:0]      ch_o,
    output logic [DWIDTH-1:0]        result_o,
    output logic                     final_o,
    output logic                     last_o,
    output logic                     ovf_o,
    output logic                     busy_o
);

    acc_state_t          state;
    logic [DWIDTH-1:0]   acc_q [NUM_CH];
    logic [NUM_CH-1:0]   ovf_q;
    logic                mode_q;
    logic                drn_wait;
    logic [CH_WIDTH-1:0] drn_k;

    logic              idle;
    logic              accept;
    logic [DWIDTH-1:0] acc_cur;
    logic [DWIDTH-1:0] alu_nxt;
    logic              ovf_cur;
    logic              op_mode;
    logic              alu_ovf;

    // A sample arriving with the session start sees a cleared channel and the incoming mode.
    assign idle    = (state == ST_IDLE);
    assign accept  = valid_i && run_i && (state != ST_DRAIN);
    assign acc_cur = idle ? '0 : acc_q[ch_i];
    assign ovf_cur = idle ? 1'b0 : ovf_q[ch_i];
    assign op_mode = idle ? mode_i : mode_q;

    acc_alu #(
        .IN_DATA_WIDTH (IN_DATA_WIDTH),
        .DWIDTH        (DWIDTH)
    ) u_alu (
        .acc    (acc_cur),
        .number (number_i),
        .mode   (op_mode),
        .nxt    (alu_nxt),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            mode_q   <= ACC_MODE_SUM;
            drn_wait <= 1'b0;
            drn_k    <= '0;
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
            ovf_q    <= '0;
            valid_o  <= 1'b0;
            ch_o     <= '0;
            result_o <= '0;
            final_o  <= 1'b0;
            last_o   <= 1'b0;
            ovf_o    <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            final_o <= 1'b0;
            last_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run_i) begin
                        for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
                        ovf_q  <= '0;
                        mode_q <= mode_i;
                        state  <= ST_RUN;
                        busy_o <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!run_i) begin
                        state    <= ST_DRAIN;
                        drn_wait <= 1'b1;
                        drn_k    <= '0;
                    end
                end
                ST_DRAIN: begin
                    // The gap cycle keeps the last echo and the first drain beat apart.
                    if (drn_wait) begin
                        drn_wait <= 1'b0;
                    end else begin
                        valid_o  <= 1'b1;
                        final_o  <= 1'b1;
                        ch_o     <= drn_k;
                        result_o <= acc_q[drn_k];
                        ovf_o    <= ovf_q[drn_k];
                        drn_k    <= drn_k + 1'b1;
                        if (drn_k == CH_WIDTH'(NUM_CH - 1)) begin
                            last_o <= 1'b1;
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
            if (accept) begin
                acc_q[ch_i] <= alu_nxt;
                ovf_q[ch_i] <= ovf_cur | alu_ovf;
                valid_o     <= 1'b1;
                ch_o        <= ch_i;
                result_o    <= alu_nxt;
                ovf_o       <= ovf_cur | alu_ovf;
            end
        end
    end

endmodule

// File: tb/tb_acc_core_mc.sv
// Self-checking bench for acc_core_mc on a 9-bit accumulator instance so sum overflow is reachable.
module tb_acc_core_mc;

    localparam int IW   = 8;
    localparam int DW   = 9;
    localparam int NC   = 4;
    localparam int CW   = 2;
    localparam int PW   = 5 + CW + DW;
    localparam int MAXV = (1 << DW) - 1;
`ifdef ACC_SAT_EN
    localparam int OVF_RES = MAXV;
`else
    localparam int OVF_RES = 765 - (MAXV + 1);
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          run_i = 1'b0, mode_i = 1'b0, valid_i = 1'b0;
    logic [CW-1:0] ch_i = '0;
    logic [IW-1:0] number_i = '0;
    logic          valid_o, final_o, last_o, ovf_o, busy_o;
    logic [CW-1:0] ch_o;
    logic [DW-1:0] result_o;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    acc_core_mc #(.IN_DATA_WIDTH(IW), .DWIDTH(DW), .NUM_CH(NC)) dut (
        .clk(clk), .reset_n(reset_n), .run_i(run_i), .mode_i(mode_i), .valid_i(valid_i),
        .ch_i(ch_i), .number_i(number_i), .valid_o(valid_o), .ch_o(ch_o), .result_o(result_o),
        .final_o(final_o), .last_o(last_o), .ovf_o(ovf_o), .busy_o(busy_o)
    );

    // Reference model: session phase, edges since run_i was seen low, plain-integer channels.
    int m_acc [NC];
    bit m_ovf [NC];
    bit m_mode;
    int m_phase;
    int m_drn;
    bit e_valid, e_final, e_last, e_busy, e_ovf;
    int e_ch, e_res;

    function automatic void m_reset();
        for (int i = 0; i < NC; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
        m_mode = 0; m_phase = 0; m_drn = 0;
        e_valid = 0; e_final = 0; e_last = 0; e_busy = 0; e_ovf = 0; e_ch = 0; e_res = 0;
    endfunction

    function automatic void m_accept(int ch, int num, bit mode);
        if (mode) begin
            if (num > m_acc[ch]) m_acc[ch] = num;
        end else begin
            int s;
            s = m_acc[ch] + num;
            if (s > MAXV) begin
                m_ovf[ch] = 1;
`ifdef ACC_SAT_EN
                s = MAXV;
`else
                s = s - (MAXV + 1);
`endif
            end
            m_acc[ch] = s;
        end
        e_valid = 1; e_ch = ch; e_res = m_acc[ch]; e_ovf = m_ovf[ch];
    endfunction

    function automatic void m_step(bit run, bit mode, bit valid, int ch, int num);
        e_valid = 0; e_final = 0; e_last = 0;
        if (m_phase == 0) begin
            if (run) begin
                for (int i = 0; i < NC; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
                m_mode = mode; m_phase = 1;
                if (valid) m_accept(ch, num, mode);
            end
        end else if (m_phase == 1) begin
            if (!run) begin m_phase = 2; m_drn = 0; end
            else if (valid) m_accept(ch, num, m_mode);
        end else begin
            m_drn++;
            if (m_drn >= 2) begin
                int k;
                k = m_drn - 2;
                e_valid = 1; e_final = 1; e_ch = k; e_res = m_acc[k]; e_ovf = m_ovf[k];
                e_last = (k == NC - 1);
                if (k == NC - 1) m_phase = 0;
            end
        end
        e_busy = (m_phase != 0);
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (fields valid,final,last,busy,ovf,ch,result)", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] dut_pk();
        return {valid_o, final_o, last_o, busy_o, ovf_o, ch_o, result_o};
    endfunction

    task automatic chk_model(input string name);
        chk(name, dut_pk(), {e_valid, e_final, e_last, e_busy, e_ovf, CW'(e_ch), DW'(e_res)});
    endtask

    task automatic step(input bit run, input bit mode, input bit valid, input int ch, input int num);
        run_i = run; mode_i = mode; valid_i = valid; ch_i = CW'(ch); number_i = IW'(num);
        m_step(run, mode, valid, ch, num);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit run, mode, valid;
        int ch, num;
        bit ev, ef, el;
        int ech, eres;
        bit eovf;
    } vec_t;
    vec_t tab[$];

    function automatic void row(bit run, bit mode, bit valid, int ch, int num,
                                bit ev, bit ef, bit el, int ech, int eres, bit eovf);
        vec_t t;
        t.run = run; t.mode = mode; t.valid = valid; t.ch = ch; t.num = num;
        t.ev = ev; t.ef = ef; t.el = el; t.ech = ech; t.eres = eres; t.eovf = eovf;
        tab.push_back(t);
    endfunction

    function automatic void idle_row(bit run, bit valid, int ch, int num);
        row(run, 0, valid, ch, num, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void drain_rows(int r0, int r1, int r2, int r3, bit o0);
        row(0, 0, 0, 0, 0, 1, 1, 0, 0, r0, o0);
        row(0, 0, 0, 0, 0, 1, 1, 0, 1, r1, 0);
        row(0, 0, 0, 0, 0, 1, 1, 0, 2, r2, 0);
        row(0, 0, 0, 0, 0, 1, 1, 1, 3, r3, 0);
        idle_row(0, 0, 0, 0);
    endfunction

    function automatic int rnd_num();
        if ($urandom_range(0, 3) == 0) return 255;
        return int'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [PW-1:0] a, e;
        int idle_n, len;
        bit md;

        // sum session with run_i rising together with the first sample
        row(1, 0, 1, 0, 1,   1, 0, 0, 0, 1, 0);
        idle_row(1, 0, 0, 0);
        row(1, 0, 1, 0, 3,   1, 0, 0, 0, 4, 0);
        idle_row(0, 1, 1, 50);
        idle_row(0, 0, 0, 0);
        drain_rows(4, 0, 0, 0, 0);
        // interleaved sum
        row(1, 0, 1, 1, 5,   1, 0, 0, 1, 5, 0);
        row(1, 0, 1, 2, 7,   1, 0, 0, 2, 7, 0);
        row(1, 0, 1, 1, 10,  1, 0, 0, 1, 15, 0);
        row(1, 0, 1, 3, 255, 1, 0, 0, 3, 255, 0);
        idle_row(0, 0, 0, 0);
        idle_row(0, 0, 0, 0);
        drain_rows(0, 15, 7, 255, 0);
        // max mode; mode_i toggles mid-session and must be ignored
        row(1, 1, 1, 2, 9,   1, 0, 0, 2, 9, 0);
        row(1, 0, 1, 2, 3,   1, 0, 0, 2, 9, 0);
        row(1, 0, 1, 2, 200, 1, 0, 0, 2, 200, 0);
        row(1, 1, 1, 2, 17,  1, 0, 0, 2, 200, 0);
        idle_row(0, 0, 0, 0);
        idle_row(0, 0, 0, 0);
        drain_rows(0, 0, 200, 0, 0);
        // sum overflow on the 9-bit accumulator
        row(1, 0, 1, 0, 255, 1, 0, 0, 0, 255, 0);
        row(1, 0, 1, 0, 255, 1, 0, 0, 0, 510, 0);
        row(1, 0, 1, 0, 255, 1, 0, 0, 0, OVF_RES, 1);
        idle_row(0, 0, 0, 0);
        idle_row(0, 0, 0, 0);
        drain_rows(OVF_RES, 0, 0, 0, 1);
        // run_i and valid_i held during drain, then back-to-back session with cleared channels
        row(1, 0, 1, 1, 20,  1, 0, 0, 1, 20, 0);
        idle_row(0, 0, 0, 0);
        idle_row(1, 1, 0, 99);
        row(1, 0, 1, 0, 99,  1, 1, 0, 0, 0, 0);
        row(1, 0, 1, 2, 99,  1, 1, 0, 1, 20, 0);
        row(1, 0, 1, 3, 99,  1, 1, 0, 2, 0, 0);
        row(1, 0, 1, 1, 99,  1, 1, 1, 3, 0, 0);
        row(1, 0, 1, 0, 7,   1, 0, 0, 0, 7, 0);
        row(1, 0, 1, 1, 1,   1, 0, 0, 1, 1, 0);
        idle_row(0, 0, 0, 0);
        idle_row(0, 0, 0, 0);
        drain_rows(7, 1, 0, 0, 0);

        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", dut_pk(), '0);
        reset_n = 1'b1;

        foreach (tab[i]) begin
            step(tab[i].run, tab[i].mode, tab[i].valid, tab[i].ch, tab[i].num);
            a = {1'b0, valid_o, final_o, last_o, ovf_o, ch_o, result_o};
            e = {1'b0, tab[i].ev, tab[i].ef, tab[i].el, tab[i].eovf, CW'(tab[i].ech), DW'(tab[i].eres)};
            if (!tab[i].ev) begin
                a[DW+CW:0] = '0;
                e[DW+CW:0] = '0;
            end
            chk($sformatf("tab%0d", i), a, e);
        end

        // reset pulsed mid-drain right after the ch1 beat
        step(1, 0, 1, 1, 8); chk_model("rst_echo");
        step(0, 0, 0, 0, 0); chk_model("rst_run_low");
        step(0, 0, 0, 0, 0); chk_model("rst_gap");
        step(0, 0, 0, 0, 0); chk_model("rst_beat0");
        step(0, 0, 0, 0, 0); chk_model("rst_beat1");
        #1 reset_n = 1'b0;
        #2;
        chk("rst_async_outputs", dut_pk(), '0);
        m_reset();
        reset_n = 1'b1;
        repeat (4) begin step(0, 0, 1, 2, 5); chk_model("rst_no_beats"); end
        step(1, 0, 1, 1, 2); chk_model("rst_new_session");
        for (int c = 0; c < NC + 2; c++) begin step(0, 0, 0, 0, 0); chk_model("rst_new_drain"); end

        // randomized sessions against the model
        for (int s = 0; s < 60; s++) begin
            idle_n = int'($urandom_range(0, 2));
            len    = int'($urandom_range(1, 16));
            md     = 1'($urandom_range(0, 1));
            for (int c = 0; c < idle_n; c++) begin
                step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), rnd_num());
                chk_model("rnd_idle");
            end
            for (int c = 0; c < len; c++) begin
                step(1, (c == 0) ? md : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), rnd_num());
                chk_model("rnd_run");
            end
            for (int c = 0; c < NC + 2; c++) begin
                step((c == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), rnd_num());
                chk_model("rnd_drain");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
